dot_product_sequencer: RTL

Streaming signed dot-product engine sitting upstream of the accelerator's output path: accepts (activation, weight) pairs over a valid/ready stream and multiplies each pair 8×8 signed. It accumulates VEC_LEN products onto a bias and returns one ACC_W-bit result per vector over a second valid/ready stream. It is the sequential counterpart to the combinational MAC datapath: it owns operand sequencing, accumulation width and result handoff.

---
 rtl/dot_product_sequencer_if.sv | 24 ++
 rtl/dot_product_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer_if.sv
// Stream bundle for dot_product_sequencer: element input stream plus result output stream.
interface dot_product_sequencer_if #(
  parameter int unsigned ACC_W = 20
);
  logic                    io_in_valid;
  logic                    io_in_ready;
  logic signed [7:0]       io_in_act;
  logic signed [7:0]       io_in_weight;
  logic signed [ACC_W-1:0] io_bias;
  logic                    io_out_valid;
  logic                    io_out_ready;
  logic signed [ACC_W-1:0] io_out_result;
  logic                    io_out_overflow;

  modport master (
    output io_in_valid, io_in_act, io_in_weight, io_bias, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_result, io_out_overflow
  );

  modport slave (
    input  io_in_valid, io_in_act, io_in_weight, io_bias, io_out_ready,
    output io_in_ready, io_out_valid, io_out_result, io_out_overflow
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Streaming signed 8x8 dot-product engine: accumulates VEC_LEN products onto a bias per vector.
// Optional saturating accumulation with sticky overflow flag when DOT_SAT_EN is defined.
module dot_product_sequencer #(
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned ACC_W   = 20
) (
  input logic              clock,
  input logic              reset,
  dot_product_sequencer_if.slave io
);

  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] result_q;
  logic                    out_valid_q;

  logic                    accept;
  logic                    first;
  logic signed [15:0]      act_ext;
  logic signed [15:0]      wt_ext;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_d;

  assign io.io_in_ready = (state_q == ACCUM) && !reset;
  assign accept         = io.io_in_valid && io.io_in_ready;
  assign first          = (count_q == '0);

  // Sign-extend both operands so the low 16 product bits are the exact signed product.
  assign act_ext  = {{8{io.io_in_act[7]}}, io.io_in_act};
  assign wt_ext   = {{8{io.io_in_weight[7]}}, io.io_in_weight};
  assign prod     = act_ext * wt_ext;
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign base     = first ? io.io_bias : acc_q;

`ifdef DOT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           clamp;
  logic           ovf_q;
  logic           ovf_d;
  logic           out_ovf_q;

  // One guard bit detects signed overflow; clamp toward the sign of the true sum.
  always_comb begin
    sum_wide = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
    clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    acc_d    = sum_wide[ACC_W-1:0];
    if (clamp) begin
      acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    ovf_d = (first ? 1'b0 : ovf_q) | clamp;
  end

  // Sticky per-vector overflow, captured into the output with the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if ((state_q == ACCUM) && accept) begin
      ovf_q <= ovf_d;
      if (count_q == LAST_IDX) begin
        out_ovf_q <= ovf_d;
      end
    end
  end

  assign io.io_out_overflow = out_ovf_q;
`else
  assign acc_d              = base + prod_ext;
  assign io.io_out_overflow = 1'b0;
`endif

  // Sequencing FSM: ACCUM consumes elements, HOLD presents the result until handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            if (count_q == LAST_IDX) begin
              count_q     <= '0;
              result_q    <= acc_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (io.io_out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign io.io_out_valid  = out_valid_q;
  assign io.io_out_result = result_q;

endmodule
